// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
// Bundles the control handshake between the multicycle controller and the
// shared RISC-V datapath.
//   master : controller side (receives the decoded instruction fields, Zero and
//            mem_ready; drives every mux select, write enable and ALUControl)
//   slave  : datapath side (the mirror image)
// Signals:
//   opcode/funct3/funct7b5 : fields of the instruction register
//   Zero                   : ALU zero flag
//   mem_ready              : memory finishes its current access this cycle
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ImmSrc, ALUControl     : datapath controls
//   illegal                : unsupported opcode seen in DECODE
//   state                  : current FSM state, for debug
interface multicycle_controller_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct3, funct7b5, Zero, mem_ready,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state
  );

  modport slave (
    output opcode, funct3, funct7b5, Zero, mem_ready,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control FSM for a multicycle RISC-V datapath that shares one memory for
// instructions and data and one ALU for PC+4, branch target and execute.
// Ports:
//   clk  : system clock, state advances on the rising edge
//   rst  : asynchronous active-high reset, forces FETCH
//   bus  : multicycle_controller_if.master (instruction fields, Zero,
//          mem_ready in; datapath controls, illegal, state out)
// Only the state register is sequential; every output is decoded
// combinationally from state and the current inputs.
//
// state    | code | meaning
// ---------+------+-----------------------------------------------------------
// FETCH    |  0   | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE   |  1   | read registers, ALUOut <= OldPC + imm (branch target)
// MEMADR   |  2   | ALUOut <= rs1 + imm (load/store address)
// MEMREAD  |  3   | read data memory at ALUOut, wait for mem_ready
// MEMWB    |  4   | rd <= loaded data
// MEMWRITE |  5   | write rs2 to memory at ALUOut, wait for mem_ready
// EXECUTER |  6   | ALUOut <= rs1 op rs2
// ALUWB    |  7   | rd <= ALUOut
// EXECUTEI |  8   | ALUOut <= rs1 op imm
// JAL      |  9   | PC <= ALUOut (target), ALUOut <= OldPC + 4
// BEQ      | 10   | compare rs1 - rs2, PC <= ALUOut when Zero
module multicycle_controller (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_controller_if.master        bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state_q;

  // ---------------------------------------------------------------------------
  // State register with next-state decode
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.mem_ready) state_q <= S_DECODE;
        end
        S_DECODE: begin
          case (bus.opcode)
            OP_LW,
            OP_SW:   state_q <= S_MEMADR;
            OP_R:    state_q <= S_EXECUTER;
            OP_IALU: state_q <= S_EXECUTEI;
            OP_JAL:  state_q <= S_JAL;
            OP_BEQ:  state_q <= S_BEQ;
            default: state_q <= S_FETCH;
          endcase
        end
        // Only lw/sw reach MEMADR, so anything that is not a store is a load.
        S_MEMADR: begin
          if (bus.opcode == OP_SW) state_q <= S_MEMWRITE;
          else                     state_q <= S_MEMREAD;
        end
        S_MEMREAD: begin
          if (bus.mem_ready) state_q <= S_MEMWB;
        end
        S_MEMWRITE: begin
          if (bus.mem_ready) state_q <= S_FETCH;
        end
        S_MEMWB:    state_q <= S_FETCH;
        S_EXECUTER,
        S_EXECUTEI,
        S_JAL:      state_q <= S_ALUWB;
        S_ALUWB:    state_q <= S_FETCH;
        S_BEQ:      state_q <= S_FETCH;
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Moore control decode (FETCH additionally gates with mem_ready)
  // ---------------------------------------------------------------------------
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       illegal_op;

  always_comb begin
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = ALUOP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC and IR only load on the cycle the instruction actually arrives.
        ir_write   = bus.mem_ready;
        pc_update  = bus.mem_ready;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (bus.opcode)
          OP_LW, OP_SW, OP_R, OP_IALU, OP_JAL, OP_BEQ: illegal_op = 1'b0;
          default:                                      illegal_op = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        // Held for the whole stall so the memory sees a stable request.
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTER: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = ALUOP_FUNCT;
      end
      S_JAL: begin
        // Target was computed in DECODE; the ALU now forms the link OldPC+4.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_op    = ALUOP_SUB;
        branch    = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // ALU decoder
  // ---------------------------------------------------------------------------
  logic [2:0] alu_control;

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (bus.funct3)
          // opcode[5] separates R-type from I-type: addi has no sub form even
          // when instr[30] happens to be set by the immediate.
          3'b000:  alu_control = (bus.opcode[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Immediate format select, purely from opcode
  // ---------------------------------------------------------------------------
  logic [1:0] imm_src;

  always_comb begin
    imm_src = 2'b00;
    case (bus.opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output drive
  // ---------------------------------------------------------------------------
  assign bus.PCWrite    = pc_update | (branch & bus.Zero);
  assign bus.AdrSrc     = adr_src;
  assign bus.MemWrite   = mem_write;
  assign bus.IRWrite    = ir_write;
  assign bus.RegWrite   = reg_write;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUControl = alu_control;
  assign bus.illegal    = illegal_op;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Directed bench for multicycle_controller. Each instruction is expanded into
// the list of states it must visit (including stall cycles); every cycle the
// DUT outputs are compared against a per-state control table plus the
// datapath rules for PCWrite, IRWrite, ALUControl, ImmSrc and illegal.
// Hand-computed literals pin sequences and key control values.
module tb_multicycle_controller;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BAD  = 7'b0000000;

  logic clk;
  logic rst;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       adr;
    logic       mw;
    logic       rw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [1:0] aop;
    logic       pcu;
    logic       br;
  } ctl_t;

  ctl_t tab [0:15];

  int n_cmp;
  int n_err;

  logic [3:0]  exp_state;
  logic [31:0] obs_seq;
  int          obs_cyc;
  int          mw_cnt;
  int          we_cnt;
  logic        obs_wb_rw;
  logic [1:0]  obs_wb_rs;
  logic [2:0]  obs_alu;
  logic        obs_beq_pcw;
  logic [2:0]  obs_beq_alu;
  logic        obs_ill;
  logic [1:0]  obs_imm;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_alu(input logic [1:0] aop, input logic [6:0] op,
                                           input logic [2:0] f3, input logic f7);
    if (aop == 2'b00) return 3'b000;
    if (aop == 2'b01) return 3'b001;
    if (f3 == 3'b000) return (op[5] && f7) ? 3'b001 : 3'b000;
    if (f3 == 3'b010) return 3'b101;
    if (f3 == 3'b110) return 3'b011;
    if (f3 == 3'b111) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [1:0] model_imm(input logic [6:0] op);
    if (op == OP_SW)  return 2'b01;
    if (op == OP_BEQ) return 2'b10;
    if (op == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic model_supported(input logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_IALU ||
           op == OP_BEQ || op == OP_JAL;
  endfunction

  task automatic compare_cycle();
    ctl_t c;
    logic fetch_rdy;
    logic exp_pcw;
    c         = tab[exp_state];
    fetch_rdy = (exp_state == 4'd0) && bus.mem_ready;
    exp_pcw   = fetch_rdy | c.pcu | (c.br & bus.Zero);
    check("state",      bus.state,              exp_state);
    check("AdrSrc",     {3'b0, bus.AdrSrc},     {3'b0, c.adr});
    check("MemWrite",   {3'b0, bus.MemWrite},   {3'b0, c.mw});
    check("RegWrite",   {3'b0, bus.RegWrite},   {3'b0, c.rw});
    check("IRWrite",    {3'b0, bus.IRWrite},    {3'b0, fetch_rdy});
    check("PCWrite",    {3'b0, bus.PCWrite},    {3'b0, exp_pcw});
    check("ResultSrc",  {2'b0, bus.ResultSrc},  {2'b0, c.rs});
    check("ALUSrcA",    {2'b0, bus.ALUSrcA},    {2'b0, c.sa});
    check("ALUSrcB",    {2'b0, bus.ALUSrcB},    {2'b0, c.sb});
    check("ImmSrc",     {2'b0, bus.ImmSrc},     {2'b0, model_imm(bus.opcode)});
    check("ALUControl", {1'b0, bus.ALUControl},
          {1'b0, model_alu(c.aop, bus.opcode, bus.funct3, bus.funct7b5)});
    check("illegal",    {3'b0, bus.illegal},
          {3'b0, (exp_state == 4'd1) && !model_supported(bus.opcode)});
  endtask

  // One clock cycle: drive mem_ready, compare at the falling edge, record
  // observations for the literal checks, then move past the next rising edge.
  task automatic step(input logic [3:0] s, input logic mr);
    bus.mem_ready = mr;
    exp_state     = s;
    @(negedge clk);
    compare_cycle();
    obs_seq = {obs_seq[27:0], bus.state};
    obs_cyc++;
    if (bus.MemWrite || bus.RegWrite) we_cnt++;
    case (s)
      4'd1:  begin obs_ill = bus.illegal; obs_imm = bus.ImmSrc; end
      4'd4:  begin obs_wb_rw = bus.RegWrite; obs_wb_rs = bus.ResultSrc; end
      4'd5:  mw_cnt += int'(bus.MemWrite);
      4'd6,
      4'd8:  obs_alu = bus.ALUControl;
      4'd10: begin obs_beq_pcw = bus.PCWrite; obs_beq_alu = bus.ALUControl; end
      default: ;
    endcase
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic z, input int fstall, input int mstall);
    bus.opcode   = op;
    bus.funct3   = f3;
    bus.funct7b5 = f7;
    bus.Zero     = z;
    obs_seq = '0; obs_cyc = 0; mw_cnt = 0; we_cnt = 0;
    for (int i = 0; i < fstall; i++) step(4'd0, 1'b0);
    step(4'd0, 1'b1);
    step(4'd1, rnd_bit());
    case (op)
      OP_LW: begin
        step(4'd2, rnd_bit());
        for (int i = 0; i < mstall; i++) step(4'd3, 1'b0);
        step(4'd3, 1'b1);
        step(4'd4, rnd_bit());
      end
      OP_SW: begin
        step(4'd2, rnd_bit());
        for (int i = 0; i < mstall; i++) step(4'd5, 1'b0);
        step(4'd5, 1'b1);
      end
      OP_R:    begin step(4'd6, rnd_bit()); step(4'd7, rnd_bit()); end
      OP_IALU: begin step(4'd8, rnd_bit()); step(4'd7, rnd_bit()); end
      OP_JAL:  begin step(4'd9, rnd_bit()); step(4'd7, rnd_bit()); end
      OP_BEQ:  step(4'd10, rnd_bit());
      default: ;
    endcase
  endtask

  task automatic release_check();
    bus.mem_ready = 1'b1;
    rst = 1'b0;
    #1;
    check("rel_state",   bus.state,             4'd0);
    check("rel_IRWrite", {3'b0, bus.IRWrite},   4'd1);
    check("rel_PCWrite", {3'b0, bus.PCWrite},   4'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) tab[i] = '0;
    //          adr  mw   rw   rs     sa     sb     aop    pcu  br
    tab[0]  = '{1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,2'b00,1'b0,1'b0};
    tab[1]  = '{1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,2'b00,1'b0,1'b0};
    tab[2]  = '{1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b00,1'b0,1'b0};
    tab[3]  = '{1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0};
    tab[4]  = '{1'b0,1'b0,1'b1,2'b01,2'b00,2'b00,2'b00,1'b0,1'b0};
    tab[5]  = '{1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0};
    tab[6]  = '{1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b10,1'b0,1'b0};
    tab[7]  = '{1'b0,1'b0,1'b1,2'b00,2'b00,2'b00,2'b00,1'b0,1'b0};
    tab[8]  = '{1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,2'b10,1'b0,1'b0};
    tab[9]  = '{1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,2'b00,1'b1,1'b0};
    tab[10] = '{1'b0,1'b0,1'b0,2'b00,2'b10,2'b00,2'b01,1'b0,1'b1};

    rst           = 1'b1;
    bus.opcode    = OP_LW;
    bus.funct3    = 3'b000;
    bus.funct7b5  = 1'b0;
    bus.Zero      = 1'b0;
    bus.mem_ready = 1'b1;

    // Reset held: FETCH values.
    repeat (2) @(posedge clk);
    #1;
    exp_state = 4'd0;
    compare_cycle();
    check("rst_MemWrite", {3'b0, bus.MemWrite}, 4'd0);
    release_check();

    // lw, no stalls
    run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 0, 0);
    check("lw_seq",   obs_seq[3:0] | {obs_seq[31:4], 4'h0} ? obs_seq[19:16] : 4'hf, 4'h0);
    check("lw_seq_lo", obs_seq[15:12], 4'h1);
    check("lw_seq_mid", obs_seq[11:0] == 12'h234 ? 4'h1 : 4'h0, 4'h1);
    check("lw_cycles", 4'(obs_cyc), 4'd5);
    check("lw_wb_RegWrite", {3'b0, obs_wb_rw}, 4'd1);
    check("lw_wb_ResultSrc", {2'b0, obs_wb_rs}, 4'd1);
    check("lw_ImmSrc", {2'b0, obs_imm}, 4'd0);

    // sw, two stall cycles in MEMWRITE
    run_instr(OP_SW, 3'b010, 1'b0, 1'b0, 0, 2);
    check("sw_seq", obs_seq[23:0] == 24'h012555 ? 4'h1 : 4'h0, 4'h1);
    check("sw_cycles", 4'(obs_cyc), 4'd6);
    check("sw_MemWrite_cycles", 4'(mw_cnt), 4'd3);
    check("sw_ImmSrc", {2'b0, obs_imm}, 4'd1);

    // R-type sub; Zero high must not leak into PCWrite
    run_instr(OP_R, 3'b000, 1'b1, 1'b1, 0, 0);
    check("sub_ALUControl", {1'b0, obs_alu}, 4'd1);
    check("r_seq", obs_seq[15:0] == 16'h0167 ? 4'h1 : 4'h0, 4'h1);

    // addi with instr[30] set stays add
    run_instr(OP_IALU, 3'b000, 1'b1, 1'b0, 0, 0);
    check("addi_ALUControl", {1'b0, obs_alu}, 4'd0);

    run_instr(OP_R, 3'b010, 1'b0, 1'b0, 0, 0);
    check("slt_ALUControl", {1'b0, obs_alu}, 4'd5);
    run_instr(OP_R, 3'b110, 1'b0, 1'b0, 0, 0);
    check("or_ALUControl", {1'b0, obs_alu}, 4'd3);
    run_instr(OP_IALU, 3'b111, 1'b0, 1'b0, 0, 0);
    check("andi_ALUControl", {1'b0, obs_alu}, 4'd2);
    run_instr(OP_IALU, 3'b011, 1'b1, 1'b0, 0, 0);
    check("other_ALUControl", {1'b0, obs_alu}, 4'd0);

    // beq taken / not taken
    run_instr(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
    check("beq_taken_PCWrite", {3'b0, obs_beq_pcw}, 4'd1);
    check("beq_ALUControl", {1'b0, obs_beq_alu}, 4'd1);
    check("beq_cycles", 4'(obs_cyc), 4'd3);
    check("beq_ImmSrc", {2'b0, obs_imm}, 4'd2);
    run_instr(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
    check("beq_nt_PCWrite", {3'b0, obs_beq_pcw}, 4'd0);

    run_instr(OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
    check("jal_cycles", 4'(obs_cyc), 4'd4);
    check("jal_ImmSrc", {2'b0, obs_imm}, 4'd3);

    // illegal opcode
    run_instr(OP_BAD, 3'b000, 1'b0, 1'b0, 0, 0);
    check("ill_seq", obs_seq[7:0] == 8'h01 ? 4'h1 : 4'h0, 4'h1);
    check("ill_cycles", 4'(obs_cyc), 4'd2);
    check("ill_flag", {3'b0, obs_ill}, 4'd1);
    check("ill_write_enables", 4'(we_cnt), 4'd0);

    // lw with fetch and read stalls
    run_instr(OP_LW, 3'b010, 1'b0, 1'b0, 1, 2);
    check("lw_stall_cycles", 4'(obs_cyc), 4'd8);

    // Reset in the middle of a stalled store
    bus.opcode = OP_SW;
    bus.funct3 = 3'b010;
    step(4'd0, 1'b1);
    step(4'd1, 1'b1);
    step(4'd2, 1'b1);
    step(4'd5, 1'b0);
    check("pre_rst_MemWrite", {3'b0, bus.MemWrite}, 4'd1);
    rst = 1'b1;
    #1;
    check("async_rst_state", bus.state, 4'd0);
    check("async_rst_MemWrite", {3'b0, bus.MemWrite}, 4'd0);
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_state = 4'd0;
    compare_cycle();
    release_check();

    run_instr(OP_R, 3'b111, 1'b0, 1'b0, 0, 0);
    check("post_rst_and", {1'b0, obs_alu}, 4'd2);
    step(4'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
